// File: rtl/seq_divider8.sv
// Sequential signed/unsigned restoring divider for the lab board: LoadA loads the dividend,
// Run latches the divisor and iterates one shift-subtract step per clock.
module seq_divider8 #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadA,
  input  logic             Run,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Qval,
  output logic [WIDTH-1:0] Rval,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic             Ovf,
  output logic [6:0]       QhexU,
  output logic [6:0]       QhexL,
  output logic [6:0]       RhexU,
  output logic [6:0]       RhexL
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, SETUP, ITER, FIXUP, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   dmag_q, dmag_d;
  logic [WIDTH:0]   qmag_q, qmag_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sq_q, sq_d, sr_q, sr_d;
  logic [WIDTH-1:0] qval_q, qval_d, rval_q, rval_d;
  logic             done_q, done_d, divzero_q, divzero_d, ovf_q, ovf_d;
  logic [6:0]       qhexu_q, qhexu_d, qhexl_q, qhexl_d, rhexu_q, rhexu_d, rhexl_q, rhexl_d;

  logic             dvd_neg, s_neg, ovf_hit;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   qneg, rneg;

  // One extra bit so that the magnitude of the most negative operand fits.
  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
    logic [WIDTH:0] ext;
    ext = {neg, v};
    return neg ? ((WIDTH+1)'(0) - ext) : ext;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    dmag_d    = dmag_q;
    qmag_d    = qmag_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    sq_d      = sq_q;
    sr_d      = sr_q;
    qval_d    = qval_q;
    rval_d    = rval_q;
    done_d    = done_q;
    divzero_d = divzero_q;
    ovf_d     = ovf_q;
    dvd_neg   = SIGNED ? dvd_q[WIDTH-1] : 1'b0;
    s_neg     = SIGNED ? S[WIDTH-1] : 1'b0;
    r_shift   = {r_q[WIDTH-1:0], qmag_q[WIDTH-1]};
    trial     = {1'b0, r_shift} - {1'b0, dmag_q};
    qneg      = (WIDTH+1)'(0) - qmag_q;
    rneg      = (WIDTH+1)'(0) - r_q;
    ovf_hit   = SIGNED && (dvd_q == MIN_VAL) && (dvs_q == {WIDTH{1'b1}});

    case (state_q)
      IDLE: begin
        // A simultaneous LoadA wins; a still-held Run starts on the following edge.
        if (!LoadA) begin
          dvd_d = S;
        end else if (!Run) begin
          state_d = SETUP;
          done_d  = 1'b0;
        end
      end
      SETUP: begin
        dvs_d  = S;
        sq_d   = dvd_neg ^ s_neg;
        sr_d   = dvd_neg;
        qmag_d = magnitude(dvd_q, dvd_neg);
        dmag_d = magnitude(S, s_neg);
        r_d    = '0;
        cnt_d  = '0;
        if (S == '0) begin
          state_d   = HOLD;
          qval_d    = '1;
          rval_d    = dvd_q;
          divzero_d = 1'b1;
          ovf_d     = 1'b0;
          done_d    = 1'b1;
        end else begin
          state_d   = ITER;
          divzero_d = 1'b0;
        end
      end
      ITER: begin
        r_d    = trial[WIDTH+1] ? r_shift : trial[WIDTH:0];
        qmag_d = {1'b0, qmag_q[WIDTH-2:0], ~trial[WIDTH+1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = FIXUP;
      end
      FIXUP: begin
        qval_d = ovf_hit ? MIN_VAL : (sq_q ? qneg[WIDTH-1:0] : qmag_q[WIDTH-1:0]);
        rval_d = ovf_hit ? '0 : (sr_q ? rneg[WIDTH-1:0] : r_q[WIDTH-1:0]);
        ovf_d  = ovf_hit;
        dvd_d  = qval_d;
        done_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    qhexu_d = hex7(qval_q[WIDTH-1 -: 4]);
    qhexl_d = hex7(qval_q[3:0]);
    rhexu_d = hex7(rval_q[WIDTH-1 -: 4]);
    rhexl_d = hex7(rval_q[3:0]);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      dmag_q    <= '0;
      qmag_q    <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      sq_q      <= 1'b0;
      sr_q      <= 1'b0;
      qval_q    <= '0;
      rval_q    <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      dmag_q    <= dmag_d;
      qmag_q    <= qmag_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      sq_q      <= sq_d;
      sr_q      <= sr_d;
      qval_q    <= qval_d;
      rval_q    <= rval_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
      ovf_q     <= ovf_d;
    end
  end

  // Display registers trail Qval/Rval by one edge, so they settle to 0 one edge after reset.
  always_ff @(posedge Clk) begin
    qhexu_q <= qhexu_d;
    qhexl_q <= qhexl_d;
    rhexu_q <= rhexu_d;
    rhexl_q <= rhexl_d;
  end

  assign Qval    = qval_q;
  assign Rval    = rval_q;
  assign Busy    = (state_q == SETUP) || (state_q == ITER) || (state_q == FIXUP);
  assign Done    = done_q;
  assign DivZero = divzero_q;
  assign Ovf     = ovf_q;
  assign QhexU   = qhexu_q;
  assign QhexL   = qhexl_q;
  assign RhexU   = rhexu_q;
  assign RhexL   = rhexl_q;

endmodule

// File: tb/tb_seq_divider8.sv
// Bench for seq_divider8: directed scenarios plus random operands against an arithmetic model.
module tb_seq_divider8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       LoadA = 1'b1;
  logic       Run = 1'b1;
  logic [7:0] S = 8'h00;
  logic [7:0] Qval, Rval;
  logic       Busy, Done, DivZero, Ovf;
  logic [6:0] QhexU, QhexL, RhexU, RhexL;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] model_dvd = 8'h00;
  logic [6:0] seg [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seq_divider8 #(.WIDTH(8), .SIGNED(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .LoadA(LoadA), .Run(Run), .S(S),
    .Qval(Qval), .Rval(Rval), .Busy(Busy), .Done(Done), .DivZero(DivZero), .Ovf(Ovf),
    .QhexU(QhexU), .QhexL(QhexL), .RhexU(RhexU), .RhexL(RhexL)
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Truncating signed division; zero divisor and -128/-1 handled as special results.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic dz, output logic ov);
    int ai, bi;
    ai = $signed(a);
    bi = $signed(b);
    dz = 1'b0;
    ov = 1'b0;
    if (b == 8'h00) begin
      q = 8'hFF; r = a; dz = 1'b1;
    end else if (a == 8'h80 && b == 8'hFF) begin
      q = 8'h80; r = 8'h00; ov = 1'b1;
    end else begin
      q = 8'(ai / bi);
      r = 8'(ai % bi);
    end
  endfunction

  task automatic do_div(input bit load, input logic [7:0] dvd, input logic [7:0] dvs,
                        input int hold_cycles, input string tag);
    logic [7:0] eq, er;
    logic edz, eov, bad;
    int n, exp_lat;
    if (load) begin
      LoadA = 1'b0; Run = 1'b0; S = dvd;
      tick;
      vectors++;
      if (Busy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s load_wins: Busy=%b want 0", tag, Busy);
      end
      LoadA = 1'b1;
      model_dvd = dvd;
    end
    model(model_dvd, dvs, eq, er, edz, eov);
    exp_lat = edz ? 1 : 10;
    Run = 1'b0; S = dvs;
    tick;
    n = 0;
    while (Done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    vectors++;
    if (n != exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d edges want %0d", tag, n, exp_lat);
    end
    vectors++;
    if ({Qval, Rval} !== {eq, er}) begin
      miscompares++;
      $display("FAIL %s result (dvd=%h dvs=%h): Q=%h R=%h want Q=%h R=%h",
               tag, model_dvd, dvs, Qval, Rval, eq, er);
    end
    vectors++;
    if ({DivZero, Ovf, Busy} !== {edz, eov, 1'b0}) begin
      miscompares++;
      $display("FAIL %s flags: DivZero/Ovf/Busy=%b%b%b want %b%b0", tag, DivZero, Ovf, Busy, edz, eov);
    end
    if (!edz) model_dvd = eq;
    if (hold_cycles > 0) begin
      bad = 1'b0;
      repeat (hold_cycles) begin
        tick;
        if (Done !== 1'b1 || Busy !== 1'b0 || Qval !== eq) bad = 1'b1;
      end
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL %s hold: restarted or lost Done (Done=%b Busy=%b Q=%h)", tag, Done, Busy, Qval);
      end
    end
    Run = 1'b1;
    tick;
    vectors++;
    if ({QhexU, QhexL, RhexU, RhexL} !== {seg[eq[7:4]], seg[eq[3:0]], seg[er[7:4]], seg[er[3:0]]}) begin
      miscompares++;
      $display("FAIL %s hex: %b %b %b %b for Q=%h R=%h", tag, QhexU, QhexL, RhexU, RhexL, eq, er);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0; LoadA = 1'b1; Run = 1'b1; S = 8'h5A;
    tick;
    tick;
    vectors++;
    if ({Qval, Rval, Busy, Done, DivZero, Ovf} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: Q=%h R=%h B=%b D=%b Z=%b O=%b want all 0",
               Qval, Rval, Busy, Done, DivZero, Ovf);
    end
    vectors++;
    if ({QhexU, QhexL, RhexU, RhexL} !== {4{seg[0]}}) begin
      miscompares++;
      $display("FAIL reset_hex: %b %b %b %b want %b", QhexU, QhexL, RhexU, RhexL, seg[0]);
    end
    Reset = 1'b1;
    model_dvd = 8'h00;
    tick;
  endtask

  task automatic test_basic;
    do_div(1'b1, 8'h64, 8'h07, 0, "basic_100_7");
  endtask

  task automatic test_signed;
    do_div(1'b1, 8'hF9, 8'h02, 0, "neg_dividend");
    do_div(1'b1, 8'h07, 8'hFE, 0, "neg_divisor");
    do_div(1'b1, 8'hEC, 8'hFB, 0, "both_neg");
  endtask

  task automatic test_divzero;
    do_div(1'b1, 8'h2A, 8'h00, 0, "divzero");
    do_div(1'b1, 8'h2A, 8'h05, 0, "divzero_clear");
  endtask

  task automatic test_ovf;
    do_div(1'b1, 8'h80, 8'hFF, 0, "ovf_min_m1");
    do_div(1'b1, 8'h80, 8'h01, 0, "min_by_1");
  endtask

  task automatic test_back_to_back;
    do_div(1'b1, 8'h64, 8'h07, 20, "chain_first");
    do_div(1'b0, 8'h00, 8'h07, 0, "chain_second");
  endtask

  task automatic test_busy_inputs;
    int n;
    LoadA = 1'b0; Run = 1'b1; S = 8'h64;
    tick;
    LoadA = 1'b1; Run = 1'b0; S = 8'h07;
    tick;
    n = 0;
    while (Done !== 1'b1 && n < 40) begin
      LoadA = (n == 4) ? 1'b0 : 1'b1;
      S     = (n == 4) ? 8'h33 : 8'h07;
      Run   = (n == 6) ? 1'b1 : 1'b0;
      tick;
      n++;
    end
    LoadA = 1'b1; Run = 1'b0;
    vectors++;
    if (n != 10 || Qval !== 8'h0E || Rval !== 8'h02) begin
      miscompares++;
      $display("FAIL busy_inputs: edges=%0d Q=%h R=%h want 10 0e 02", n, Qval, Rval);
    end
    Run = 1'b1;
    tick;
    model_dvd = 8'h0E;
    do_div(1'b0, 8'h00, 8'h07, 0, "busy_chain");
  endtask

  task automatic test_reset_mid_iter;
    LoadA = 1'b0; S = 8'h64;
    tick;
    LoadA = 1'b1; Run = 1'b0; S = 8'h07;
    tick;
    repeat (5) tick;
    vectors++;
    if (Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_iter_busy: Busy=%b want 1", Busy);
    end
    Reset = 1'b0;
    tick;
    vectors++;
    if ({Qval, Rval, Busy, Done, DivZero, Ovf} !== 20'h0) begin
      miscompares++;
      $display("FAIL mid_iter_reset: Q=%h R=%h B=%b D=%b Z=%b O=%b want all 0",
               Qval, Rval, Busy, Done, DivZero, Ovf);
    end
    Reset = 1'b1; Run = 1'b1;
    model_dvd = 8'h00;
    tick;
    do_div(1'b0, 8'h00, 8'h03, 0, "after_reset");
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    repeat (30) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      do_div(1'b1, a, b, 0, "random");
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signed;
    test_divzero;
    test_ovf;
    test_back_to_back;
    test_busy_inputs;
    test_reset_mid_iter;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
